spi_tx_byte_feeder: RTL and testbench

//  Upstream stage of the SPI-slave MISO shifter. Buffers bytes from the system side in a small FIFO.

---
 rtl/spi_tx_byte_feeder.sv | 150 +++++++++++++++
 tb/tb_spi_tx_byte_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_byte_feeder.sv
// spi_tx_byte_feeder
// Feeds bytes from a small FIFO to the parallel input of an SPI-slave MISO
// shifter. SCLK/CS are synchronised into clk to count shifted bits, so a byte
// can be retired once all 8 of its bits have gone out. The next byte is then
// loaded from the FIFO.
module spi_tx_byte_feeder #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       SCLK,
  input  logic                       CS,
  output logic [7:0]                 miso,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       byte_done,
  output logic                       underrun,
  output logic                       cs_abort
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  // Pin order for the synchroniser bank: bit 0 = SCLK, bit 1 = CS.
  logic [1:0] pin_w;
  logic [1:0] sync_w;
  logic [1:0] prev_w;

  assign pin_w = {CS, SCLK};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      logic prev_reg;

      // Two-flop synchroniser plus one delayed copy for edge detection.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
          prev_reg <= 1'b0;
        end else begin
          meta_reg <= pin_w[gi];
          sync_reg <= meta_reg;
          prev_reg <= sync_reg;
        end
      end

      assign sync_w[gi] = sync_reg;
      assign prev_w[gi] = prev_reg;
    end
  endgenerate

  logic cs_s;
  logic sclk_rise;
  logic cs_fall;

  assign cs_s      = sync_w[1];
  assign sclk_rise = sync_w[0] & ~prev_w[0];
  assign cs_fall   = ~sync_w[1] & prev_w[1];

  // FIFO storage and state.
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic          hold_valid_reg;
  logic [2:0]    bit_cnt_reg;

  logic do_write;
  logic do_load;
  logic byte_end;

  assign wr_ready = (level != LW'(DEPTH));
  assign do_write = wr_valid & wr_ready;
  // Loads only happen on a byte boundary (or with the frame closed), so miso
  // never changes while the shifter is part-way through a byte.
  assign do_load  = ~hold_valid_reg & (level != '0) & (~cs_s | (bit_cnt_reg == 3'd0));
  assign byte_end = sclk_rise & cs_s & (bit_cnt_reg == 3'd7);

  // Storage array has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Bit counting, byte retire/load, FIFO pointers and the event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level          <= '0;
      hold_valid_reg <= 1'b0;
      miso           <= IDLE_BYTE;
      bit_cnt_reg    <= 3'd0;
      byte_done      <= 1'b0;
      underrun       <= 1'b0;
      cs_abort       <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      underrun  <= 1'b0;
      cs_abort  <= 1'b0;

      // A closed frame resets bit position; a partial byte is flagged but the
      // held byte stays so it is resent from bit 0 in the next frame.
      if (!cs_s) begin
        bit_cnt_reg <= 3'd0;
        if (cs_fall && (bit_cnt_reg != 3'd0)) begin
          cs_abort <= 1'b1;
        end
      end else if (sclk_rise) begin
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end

      // Retire requires a held byte and load requires none, so they are
      // mutually exclusive within a cycle.
      if (byte_end) begin
        if (hold_valid_reg) begin
          byte_done      <= 1'b1;
          hold_valid_reg <= 1'b0;
          miso           <= IDLE_BYTE;
        end else begin
          underrun <= 1'b1;
        end
      end

      if (do_load) begin
        hold_valid_reg <= 1'b1;
        miso           <= mem[rd_ptr_reg];
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
      end

      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end

      case ({do_write, do_load})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_byte_feeder.sv
// Bench for spi_tx_byte_feeder: a queue-based reference model tracks what the
// feeder must present each cycle, a compare process checks it on every falling
// clk edge, and directed scenarios pin the model with literal expectations.
module tb_spi_tx_byte_feeder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       SCLK;
  logic       CS;
  logic [7:0] miso;
  logic [2:0] level;
  logic       byte_done;
  logic       underrun;
  logic       cs_abort;

  int tests = 0;
  int fails = 0;
  int cnt_done = 0;
  int cnt_under = 0;
  int cnt_abort = 0;
  int cyc_no = 0;

  spi_tx_byte_feeder #(.DEPTH(DEPTH), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .SCLK(SCLK), .CS(CS), .miso(miso), .level(level),
    .byte_done(byte_done), .underrun(underrun), .cs_abort(cs_abort)
  );

  always #5 clk = ~clk;

  // Reference model: pins become visible to the feeder two clk samples late.
  logic [7:0] m_q[$];
  bit         m_hold = 0;
  logic [7:0] m_miso = 8'hFF;
  int         m_bits = 0;
  bit         m_done = 0, m_under = 0, m_abort = 0;
  bit   [2:0] h_sclk = 0, h_cs = 0;
  bit         m_rise, m_vcs, m_pcs, m_load;
  int         m_lvl;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_hold = 0; m_miso = 8'hFF; m_bits = 0;
      m_done = 0; m_under = 0; m_abort = 0;
      h_sclk = 0; h_cs = 0;
    end else begin
      m_rise = h_sclk[1] && !h_sclk[2];
      m_vcs  = h_cs[1];
      m_pcs  = h_cs[2];
      m_lvl  = m_q.size();
      m_load = !m_hold && (m_lvl > 0) && (!m_vcs || m_bits == 0);
      m_done = 0; m_under = 0; m_abort = 0;
      if (!m_vcs) begin
        if (m_pcs && m_bits != 0) m_abort = 1;
        m_bits = 0;
      end else if (m_rise) begin
        if (m_bits == 7) begin
          if (m_hold) begin m_done = 1; m_hold = 0; m_miso = 8'hFF; end
          else m_under = 1;
        end
        m_bits = (m_bits + 1) % 8;
      end
      if (m_load) begin m_miso = m_q.pop_front(); m_hold = 1; end
      if (wr_valid && m_lvl < DEPTH) m_q.push_back(wr_data);
      h_sclk = {h_sclk[1:0], SCLK};
      h_cs   = {h_cs[1:0], CS};
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    cyc_no++;
    tests++;
    if (miso !== m_miso || level !== 3'(m_q.size()) ||
        wr_ready !== (m_q.size() != DEPTH) || byte_done !== m_done ||
        underrun !== m_under || cs_abort !== m_abort) begin
      fails++;
      $display("FAIL cycle_cmp cyc=%0d got miso=%h lvl=%0d rdy=%b d/u/a=%b%b%b required miso=%h lvl=%0d rdy=%b d/u/a=%b%b%b",
               cyc_no, miso, level, wr_ready, byte_done, underrun, cs_abort,
               m_miso, m_q.size(), (m_q.size() != DEPTH), m_done, m_under, m_abort);
    end
    if (byte_done === 1'b1) cnt_done++;
    if (underrun === 1'b1) cnt_under++;
    if (cs_abort === 1'b1) cnt_abort++;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %0h required %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr_byte(input logic [7:0] b);
    wr_data = b; wr_valid = 1'b1; cyc(1); wr_valid = 1'b0;
  endtask

  // SCLK period is 8 clk, meeting the f_clk >= 8*f_SCLK requirement.
  task automatic sclk_bits(input int n);
    repeat (n) begin SCLK = 1'b1; cyc(4); SCLK = 1'b0; cyc(4); end
  endtask

  int d0, u0, a0;
  logic [7:0] exp_b;

  initial begin
    rst = 1'b1; wr_data = 8'h00; wr_valid = 1'b0; SCLK = 1'b0; CS = 1'b0;
    cyc(3);
    rst = 1'b0;
    cyc(2);
    chk("reset_miso", miso, 8'hFF);
    chk("reset_level", level, 0);
    chk("reset_wr_ready", wr_ready, 1);

    // Single byte: no bypass, then a full frame retires it.
    d0 = cnt_done;
    wr_byte(8'hA5);
    chk("a5_no_bypass", miso, 8'hFF);
    cyc(1);
    chk("a5_loaded", miso, 8'hA5);
    chk("a5_level", level, 0);
    CS = 1'b1; cyc(3); sclk_bits(8); cyc(4); CS = 1'b0; cyc(6);
    chk("a5_byte_done_cnt", cnt_done - d0, 1);
    chk("a5_miso_idle", miso, 8'hFF);

    // Fill past capacity, pointers wrap, drain in order.
    d0 = cnt_done;
    wr_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin wr_data = 8'(i); cyc(1); end
    wr_valid = 1'b0;
    chk("fill_miso", miso, 8'h01);
    chk("fill_level", level, 4);
    chk("fill_wr_ready", wr_ready, 0);
    wr_byte(8'h06);
    chk("full_write_ignored_level", level, 4);
    CS = 1'b1; cyc(3);
    for (int k = 0; k < 5; k++) begin
      exp_b = 8'(k + 1);
      chk($sformatf("fill_order_%0d", k), miso, exp_b);
      sclk_bits(8);
    end
    cyc(4); CS = 1'b0; cyc(6);
    chk("fill_byte_done_cnt", cnt_done - d0, 5);
    chk("fill_drained_miso", miso, 8'hFF);
    chk("fill_drained_level", level, 0);

    // Underrun: frame with nothing held.
    d0 = cnt_done; u0 = cnt_under;
    CS = 1'b1; cyc(3); sclk_bits(8); cyc(4); CS = 1'b0; cyc(6);
    chk("underrun_cnt", cnt_under - u0, 1);
    chk("underrun_no_done", cnt_done - d0, 0);
    chk("underrun_miso", miso, 8'hFF);

    // Abort after 3 bits keeps the byte; the next full frame sends it.
    d0 = cnt_done; a0 = cnt_abort;
    wr_byte(8'h3C); cyc(2);
    CS = 1'b1; cyc(3); sclk_bits(3); cyc(2); CS = 1'b0; cyc(6);
    chk("abort_cnt", cnt_abort - a0, 1);
    chk("abort_miso_kept", miso, 8'h3C);
    CS = 1'b1; cyc(3); sclk_bits(8); cyc(4); CS = 1'b0; cyc(6);
    chk("abort_resend_done", cnt_done - d0, 1);
    chk("abort_resend_idle", miso, 8'hFF);

    // Simultaneous write and pop at level 2.
    d0 = cnt_done;
    CS = 1'b1; cyc(3); sclk_bits(3);
    wr_valid = 1'b1;
    wr_data = 8'h11; cyc(1);
    wr_data = 8'h22; cyc(1);
    wr_valid = 1'b0;
    cyc(2);
    chk("sim_pre_level", level, 2);
    chk("sim_pre_miso", miso, 8'hFF);
    CS = 1'b0; cyc(2);
    wr_byte(8'h33);
    chk("sim_level_kept", level, 2);
    chk("sim_miso_head", miso, 8'h11);
    cyc(6);
    CS = 1'b1; cyc(3);
    for (int k = 0; k < 3; k++) begin
      exp_b = 8'((k + 1) * 8'h11);
      chk($sformatf("sim_order_%0d", k), miso, exp_b);
      sclk_bits(8);
    end
    cyc(4); CS = 1'b0; cyc(6);
    chk("sim_byte_done_cnt", cnt_done - d0, 3);
    chk("sim_level_empty", level, 0);

    // Reset mid-frame with a held byte and a queued byte.
    a0 = cnt_abort;
    wr_byte(8'h77); wr_byte(8'h88); cyc(2);
    CS = 1'b1; cyc(3); sclk_bits(3);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("rst_mid_miso", miso, 8'hFF);
    chk("rst_mid_level", level, 0);
    chk("rst_mid_wr_ready", wr_ready, 1);
    chk("rst_mid_pulses", {byte_done, underrun, cs_abort}, 0);
    cyc(2);
    rst = 1'b0;
    CS = 1'b0; cyc(8);
    chk("rst_mid_no_abort", cnt_abort - a0, 0);
    chk("rst_mid_miso_after", miso, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
